// File: rtl/pattern_gen_480p.sv
// pattern_gen_480p
//   Test-pattern generator for the 480p HDMI path. It takes the pixel
//   coordinate and timing from the display timing generator and produces
//   registered RGB. The syncs and DE are delayed so they stay aligned with
//   the colour. Mode and square position change only at the frame tick, so a
//   mode switch never tears a frame.
//
// Ports
//   i_clk_pxl        pixel clock
//   i_reset          asynchronous, active-high reset
//   i_mode           pattern request: 0 solid, 1 static square, 2 bars, 3 bouncing
//   i_sx, i_sy       current pixel coordinate
//   i_de/i_hsync/i_vsync  timing signals paired with i_sx/i_sy
//   o_r/o_g/o_b      pixel colour, 2 cycles after the coordinate
//   o_de/o_hsync/o_vsync  timing delayed by 2 cycles
//   o_frame_tick     frame-boundary pulse, aligned with the outputs
module pattern_gen_480p #(
  parameter int COORD_BITS  = 10,
  parameter int COLOUR_BITS = 4,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SQ_SIZE     = 200,
  parameter int SPEED       = 2,
  parameter int BG_R        = 1,
  parameter int BG_G        = 3,
  parameter int BG_B        = 7
) (
  input  logic                   i_clk_pxl,
  input  logic                   i_reset,
  input  logic [1:0]             i_mode,
  input  logic [COORD_BITS-1:0]  i_sx,
  input  logic [COORD_BITS-1:0]  i_sy,
  input  logic                   i_de,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  output logic [COLOUR_BITS-1:0] o_r,
  output logic [COLOUR_BITS-1:0] o_g,
  output logic [COLOUR_BITS-1:0] o_b,
  output logic                   o_de,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_frame_tick
);

  // One extra bit so position sums and region limits cannot wrap.
  typedef logic [COORD_BITS:0] wide_t;

  localparam int X_MAX = H_RES - SQ_SIZE;
  localparam int Y_MAX = V_RES - SQ_SIZE;
  localparam int BAR_W = H_RES / 8;

  localparam logic [1:0] MODE_SOLID  = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_BARS   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic [COLOUR_BITS-1:0] ONES = '1;

  logic       frame_tick;
  logic [1:0] mode_reg;
  logic [1:0] mode_next;
  logic [1:0] in_range;   // bit 0: x inside square span, bit 1: y inside
  logic [7:1] bar_ge;     // thermometer code of sx against bar boundaries
  logic [2:0] bar_idx;

  // First pixel of the first vertical-blank line.
  assign frame_tick = (i_sx == '0) && (i_sy == COORD_BITS'(V_RES));
  assign mode_next  = frame_tick ? i_mode : mode_reg;

  always_ff @(posedge i_clk_pxl or posedge i_reset) begin
    if (i_reset) mode_reg <= MODE_SQUARE;
    else         mode_reg <= mode_next;
  end

  // Per-axis position/direction state and square span test. Axis 0 is X,
  // axis 1 is Y; both axes share the same bounce rule with their own limit.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int MAX = (gi == 0) ? X_MAX : Y_MAX;
      localparam logic [COORD_BITS-1:0] START = COORD_BITS'(MAX / 2);
      localparam wide_t MAX_W   = wide_t'(MAX);
      localparam wide_t SPEED_W = wide_t'(SPEED);
      localparam wide_t SIZE_W  = wide_t'(SQ_SIZE);

      logic [COORD_BITS-1:0] coord;
      logic [COORD_BITS-1:0] origin;
      logic [COORD_BITS-1:0] pos_reg;
      logic [COORD_BITS-1:0] pos_next;
      logic                  dir_up_reg;
      logic                  dir_up_next;
      wide_t                 fwd_sum;

      assign coord   = (gi == 0) ? i_sx : i_sy;
      assign fwd_sum = {1'b0, pos_reg} + SPEED_W;

      always_comb begin
        pos_next    = pos_reg;
        dir_up_next = dir_up_reg;
        if (frame_tick) begin
          if (mode_reg == MODE_BOUNCE) begin
            if (dir_up_reg) begin
              if (fwd_sum >= MAX_W) begin
                pos_next    = MAX_W[COORD_BITS-1:0];
                dir_up_next = 1'b0;
              end else begin
                pos_next = fwd_sum[COORD_BITS-1:0];
              end
            end else begin
              if ({1'b0, pos_reg} <= SPEED_W) begin
                pos_next    = '0;
                dir_up_next = 1'b1;
              end else begin
                pos_next = pos_reg - SPEED_W[COORD_BITS-1:0];
              end
            end
          end else if (i_mode == MODE_BOUNCE) begin
            // Entering bounce mode restarts from the centre, moving (+,+).
            pos_next    = START;
            dir_up_next = 1'b1;
          end
        end
      end

      always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
          pos_reg    <= START;
          dir_up_reg <= 1'b1;
        end else begin
          pos_reg    <= pos_next;
          dir_up_reg <= dir_up_next;
        end
      end

      // Static square sits at the centre; bouncing square follows pos_reg.
      assign origin       = (mode_reg == MODE_BOUNCE) ? pos_reg : START;
      assign in_range[gi] = ({1'b0, coord} >= {1'b0, origin}) &&
                            ({1'b0, coord} <  ({1'b0, origin} + SIZE_W));
    end

    for (gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi] = ({1'b0, i_sx} >= wide_t'(gi * BAR_W));
    end
  endgenerate

  // The comparator outputs are monotonic, so their population count is the
  // bar index.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) bar_idx = bar_idx + 3'(bar_ge[i]);
  end

  // Stage 1: region flag, bar index, mode and delayed timing.
  logic       s1_sq_reg;
  logic [2:0] s1_bar_reg;
  logic [1:0] s1_mode_reg;
  logic       s1_de_reg;
  logic       s1_hs_reg;
  logic       s1_vs_reg;
  logic       s1_tick_reg;

  always_ff @(posedge i_clk_pxl or posedge i_reset) begin
    if (i_reset) begin
      s1_sq_reg   <= 1'b0;
      s1_bar_reg  <= '0;
      s1_mode_reg <= '0;
      s1_de_reg   <= 1'b0;
      s1_hs_reg   <= 1'b0;
      s1_vs_reg   <= 1'b0;
      s1_tick_reg <= 1'b0;
    end else begin
      s1_sq_reg   <= &in_range;
      s1_bar_reg  <= bar_idx;
      s1_mode_reg <= mode_reg;
      s1_de_reg   <= i_de;
      s1_hs_reg   <= i_hsync;
      s1_vs_reg   <= i_vsync;
      s1_tick_reg <= frame_tick;
    end
  end

  // Stage 2 colour select.
  logic [COLOUR_BITS-1:0] r_next;
  logic [COLOUR_BITS-1:0] g_next;
  logic [COLOUR_BITS-1:0] b_next;

  always_comb begin
    r_next = COLOUR_BITS'(BG_R);
    g_next = COLOUR_BITS'(BG_G);
    b_next = COLOUR_BITS'(BG_B);
    case (s1_mode_reg)
      MODE_SQUARE, MODE_BOUNCE: begin
        if (s1_sq_reg) begin
          r_next = ONES;
          g_next = ONES;
          b_next = ONES;
        end
      end
      MODE_BARS: begin
        // Bar order W,Y,C,G,M,R,B,K: red is off when idx[1] is set,
        // green when idx[2] is set, blue when idx[0] is set.
        r_next = s1_bar_reg[1] ? '0 : ONES;
        g_next = s1_bar_reg[2] ? '0 : ONES;
        b_next = s1_bar_reg[0] ? '0 : ONES;
      end
      default: ;
    endcase
    if (!s1_de_reg) begin
      r_next = '0;
      g_next = '0;
      b_next = '0;
    end
  end

  always_ff @(posedge i_clk_pxl or posedge i_reset) begin
    if (i_reset) begin
      o_r          <= '0;
      o_g          <= '0;
      o_b          <= '0;
      o_de         <= 1'b0;
      o_hsync      <= 1'b0;
      o_vsync      <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      o_r          <= r_next;
      o_g          <= g_next;
      o_b          <= b_next;
      o_de         <= s1_de_reg;
      o_hsync      <= s1_hs_reg;
      o_vsync      <= s1_vs_reg;
      o_frame_tick <= s1_tick_reg;
    end
  end

endmodule

// File: tb/tb_pattern_gen_480p.sv
// Testbench for pattern_gen_480p: table of single-pixel vectors plus
// hand-written sequences for reset, latency, mode switching and bouncing.
module tb_pattern_gen_480p;

  logic       clk_pxl = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [9:0] sx, sy;
  logic       de, hs, vs;
  logic [3:0] r, g, b;
  logic       o_de, o_hs, o_vs, o_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_mode;

  always #20 clk_pxl = ~clk_pxl;

  pattern_gen_480p dut (
    .i_clk_pxl   (clk_pxl),
    .i_reset     (rst),
    .i_mode      (mode),
    .i_sx        (sx),
    .i_sy        (sy),
    .i_de        (de),
    .i_hsync     (hs),
    .i_vsync     (vs),
    .o_r         (r),
    .o_g         (g),
    .o_b         (b),
    .o_de        (o_de),
    .o_hsync     (o_hs),
    .o_vsync     (o_vs),
    .o_frame_tick(o_tick)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        d;
    logic        h;
    logic        v;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] m, input int x, input int y,
                              input logic d, input logic h, input logic v,
                              input logic [11:0] rgb);
    vec_t e;
    e.mode = m; e.x = 10'(x); e.y = 10'(y);
    e.d = d; e.h = h; e.v = v; e.rgb = rgb;
    vecs.push_back(e);
  endfunction

  // {rgb, de, hsync, vsync, frame_tick}
  function automatic logic [15:0] outs();
    return {r, g, b, o_de, o_hs, o_vs, o_tick};
  endfunction

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp, input bit quiet);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end else if (!quiet) begin
      $display("[TB] ok   %s: %h", name, got);
    end
  endtask

  task automatic idle();
    sx = 10'd1; sy = 10'd0; de = 1'b0; hs = 1'b0; vs = 1'b0;
  endtask

  // Present one pixel for one cycle; its result is sampled 2 cycles later.
  task automatic probe(input string name, input int x, input int y,
                       input logic d, input logic h, input logic v,
                       input logic [11:0] rgb, input bit quiet);
    sx = 10'(x); sy = 10'(y); de = d; hs = h; vs = v;
    @(posedge clk_pxl); #1;
    idle();
    @(posedge clk_pxl); #1;
    check(name, outs(), {rgb, d, h, v, 1'b0}, quiet);
  endtask

  // Frame tick with a mode request; o_frame_tick must pulse exactly at +2.
  task automatic do_tick(input logic [1:0] m);
    mode = m; sx = 10'd0; sy = 10'd480; de = 1'b0; hs = 1'b0; vs = 1'b1;
    @(posedge clk_pxl); #1;
    idle();
    check("tick_c1", {15'b0, o_tick}, 16'd0, 1'b1);
    @(posedge clk_pxl); #1;
    check("tick_c2", {15'b0, o_tick}, 16'd1, 1'b1);
    @(posedge clk_pxl); #1;
    check("tick_c3", {15'b0, o_tick}, 16'd0, 1'b1);
    cur_mode = int'(m);
  endtask

  int mx, my;
  bit dx, dy;
  int nticks, tick_at;

  initial begin
    // ---------------- reset at start ----------------
    rst = 1'b1; mode = 2'd1; idle();
    cur_mode = 1;
    repeat (3) @(posedge clk_pxl);
    #1;
    check("reset_outputs", outs(), 16'h0000, 1'b0);
    rst = 1'b0;

    // ---------------- latency: exactly 2 cycles ----------------
    sx = 10'd220; sy = 10'd140; de = 1'b1; hs = 1'b1; vs = 1'b0;
    @(posedge clk_pxl); #1;
    idle();
    check("latency_c1", outs(), 16'h0000, 1'b0);
    @(posedge clk_pxl); #1;
    check("latency_c2", outs(), {12'hFFF, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
    @(posedge clk_pxl); #1;
    check("latency_c3", outs(), 16'h0000, 1'b0);

    // ---------------- table of single-pixel vectors ----------------
    add(2'd1, 220, 140, 1, 0, 0, 12'hFFF);
    add(2'd1, 219, 140, 1, 0, 0, 12'h137);
    add(2'd1, 220, 139, 1, 0, 0, 12'h137);
    add(2'd1, 419, 339, 1, 0, 0, 12'hFFF);
    add(2'd1, 420, 339, 1, 0, 0, 12'h137);
    add(2'd1, 419, 340, 1, 0, 0, 12'h137);
    add(2'd1, 300, 300, 0, 1, 0, 12'h000);
    add(2'd1,   0,   0, 1, 0, 0, 12'h137);
    add(2'd2,   0,  10, 1, 0, 0, 12'hFFF);
    add(2'd2,  79,  10, 1, 0, 0, 12'hFFF);
    add(2'd2,  80,  10, 1, 0, 0, 12'hFF0);
    add(2'd2, 160,  10, 1, 0, 0, 12'h0FF);
    add(2'd2, 240,  10, 1, 0, 0, 12'h0F0);
    add(2'd2, 320,  10, 1, 0, 0, 12'hF0F);
    add(2'd2, 400,  10, 1, 0, 0, 12'hF00);
    add(2'd2, 480,  10, 1, 0, 0, 12'h00F);
    add(2'd2, 560,  10, 1, 0, 0, 12'h000);
    add(2'd2, 639,  10, 1, 0, 0, 12'h000);
    add(2'd2, 100,   5, 0, 0, 1, 12'h000);
    add(2'd0, 220, 140, 1, 0, 0, 12'h137);
    add(2'd0,   0,   0, 1, 0, 0, 12'h137);
    add(2'd0, 300, 200, 0, 1, 1, 12'h000);
    add(2'd3, 220, 140, 1, 0, 0, 12'hFFF);
    add(2'd3, 219, 140, 1, 0, 0, 12'h137);

    for (int i = 0; i < vecs.size(); i++) begin
      if (int'(vecs[i].mode) != cur_mode) do_tick(vecs[i].mode);
      probe($sformatf("vec%0d_m%0d(%0d,%0d)", i, vecs[i].mode, vecs[i].x, vecs[i].y),
            int'(vecs[i].x), int'(vecs[i].y), vecs[i].d, vecs[i].h, vecs[i].v,
            vecs[i].rgb, 1'b0);
    end

    // ---------------- bouncing square, 300 frames ----------------
    mx = 220; my = 140; dx = 1'b1; dy = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      int f0;
      do_tick(2'd3);
      if (dx) begin
        if (mx + 2 >= 440) begin mx = 440; dx = 1'b0; end else mx = mx + 2;
      end else begin
        if (mx <= 2) begin mx = 0; dx = 1'b1; end else mx = mx - 2;
      end
      if (dy) begin
        if (my + 2 >= 280) begin my = 280; dy = 1'b0; end else my = my + 2;
      end else begin
        if (my <= 2) begin my = 0; dy = 1'b1; end else my = my - 2;
      end
      f0 = n_fail;
      probe($sformatf("bnc%0d_tl", k), mx, my, 1, 0, 0, 12'hFFF, 1'b1);
      probe($sformatf("bnc%0d_br", k), mx + 199, my + 199, 1, 0, 0, 12'hFFF, 1'b1);
      probe($sformatf("bnc%0d_right", k), mx + 200, my + 199, 1, 0, 0, 12'h137, 1'b1);
      if (mx > 0) probe($sformatf("bnc%0d_left", k), mx - 1, my, 1, 0, 0, 12'h137, 1'b1);
      if (my > 0) probe($sformatf("bnc%0d_above", k), mx, my - 1, 1, 0, 0, 12'h137, 1'b1);
      if (my + 200 < 480) probe($sformatf("bnc%0d_below", k), mx, my + 200, 1, 0, 0, 12'h137, 1'b1);
      // Hand-computed turning points.
      case (k)
        70:  probe("bnc70_y_peak",   360, 280, 1, 0, 0, 12'hFFF, 1'b1);
        110: probe("bnc110_x_clamp", 440, 200, 1, 0, 0, 12'hFFF, 1'b1);
        111: probe("bnc111_x_back",  437, 198, 1, 0, 0, 12'h137, 1'b1);
        210: probe("bnc210_y_zero",  240,   0, 1, 0, 0, 12'hFFF, 1'b1);
        211: probe("bnc211_y_up",    238,   1, 1, 0, 0, 12'h137, 1'b1);
        default: ;
      endcase
      $display("[TB] frame %0d pos=(%0d,%0d) %s", k, mx, my,
               (n_fail == f0) ? "ok" : "bad");
    end

    // ---------------- mode 3 -> 0 -> 3 ----------------
    do_tick(2'd0);
    probe("m0_centre", 220, 140, 1, 0, 0, 12'h137, 1'b0);
    probe("m0_oldpos", 250, 180, 1, 0, 0, 12'h137, 1'b0);
    do_tick(2'd0);
    do_tick(2'd0);
    do_tick(2'd3);
    probe("reentry_tl",    220, 140, 1, 0, 0, 12'hFFF, 1'b0);
    probe("reentry_left",  219, 140, 1, 0, 0, 12'h137, 1'b0);
    probe("reentry_br",    419, 339, 1, 0, 0, 12'hFFF, 1'b0);
    probe("reentry_right", 420, 339, 1, 0, 0, 12'h137, 1'b0);
    probe("reentry_above", 220, 139, 1, 0, 0, 12'h137, 1'b0);
    do_tick(2'd3);
    probe("reentry_step_tl",   222, 142, 1, 0, 0, 12'hFFF, 1'b0);
    probe("reentry_step_left", 221, 142, 1, 0, 0, 12'h137, 1'b0);

    // ---------------- mode change mid-frame ----------------
    do_tick(2'd1);
    mode = 2'd2;  // requested at sy = 100
    probe("midframe_sy100", 0, 100, 1, 0, 0, 12'h137, 1'b0);
    probe("midframe_sy150", 0, 150, 1, 0, 0, 12'h137, 1'b0);
    probe("midframe_sq",  230, 300, 1, 0, 0, 12'hFFF, 1'b0);
    nticks = 0; tick_at = -1;
    for (int j = 0; j < 8; j++) begin
      sx = 10'(j); sy = 10'd480; de = 1'b0; hs = 1'b0; vs = 1'b1;
      @(posedge clk_pxl); #1;
      if (o_tick) begin nticks++; tick_at = j; end
    end
    idle();
    check("midframe_tick_count", 16'(nticks), 16'd1, 1'b0);
    check("midframe_tick_pos", 16'(tick_at), 16'd1, 1'b0);
    probe("nextframe_white",  0, 10, 1, 0, 0, 12'hFFF, 1'b0);
    probe("nextframe_yellow", 80, 10, 1, 0, 0, 12'hFF0, 1'b0);

    // ---------------- reset mid-line ----------------
    sx = 10'd300; sy = 10'd200; de = 1'b1; hs = 1'b1; vs = 1'b1;
    repeat (3) @(posedge clk_pxl);
    #1;
    check("pre_reset_green", outs(), {12'h0F0, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b0);
    #5 rst = 1'b1;
    #1;
    check("reset_async", outs(), 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_pxl); #1;
      check($sformatf("reset_hold%0d", i), outs(), 16'h0000, 1'b0);
    end
    rst = 1'b0;
    @(posedge clk_pxl); #1;
    check("release_c1", outs(), 16'h0000, 1'b0);
    @(posedge clk_pxl); #1;
    check("release_c2", outs(), {12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b0);
    @(posedge clk_pxl); #1;
    check("release_c3", outs(), {12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b0);
    idle();
    @(posedge clk_pxl); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
